// File: rtl/i2c_cfg_pkg.sv
// ============================================================================
// Module  : i2c_cfg_pkg
// Brief   : Shared types and constants for the I2C register-table sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_cfg_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE     = 4'd0;
    localparam state_t ST_FETCH    = 4'd1;
    localparam state_t ST_DECODE   = 4'd2;
    localparam state_t ST_ISSUE    = 4'd3;
    localparam state_t ST_WAIT_RSP = 4'd4;
    localparam state_t ST_WAIT_DLY = 4'd5;
    localparam state_t ST_NEXT     = 4'd6;
    localparam state_t ST_DONE     = 4'd7;
    localparam state_t ST_ERROR    = 4'd8;

    localparam logic [7:0] END_REG   = 8'hFF;
    localparam logic [7:0] END_VAL   = 8'hFF;
    localparam logic [7:0] DELAY_REG = 8'hFE;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] val;
    } entry_t;

    typedef enum logic [1:0] {
        ENT_WRITE = 2'd0,
        ENT_DELAY = 2'd1,
        ENT_END   = 2'd2
    } entry_kind_e;

    function automatic entry_kind_e classify(input entry_t e);
        if (e.addr == END_REG && e.val == END_VAL) return ENT_END;
        else if (e.addr == DELAY_REG)              return ENT_DELAY;
        else                                       return ENT_WRITE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cfg_delay_timer.sv
// ============================================================================
// Module  : cfg_delay_timer
// Brief   : Tick down-counter with a DELAY_UNIT prescaler; expired_o pulses in
//           the last cycle of a ticks_i*DELAY_UNIT cycle interval.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cfg_delay_timer #(
    parameter int DELAY_UNIT = 100000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic [7:0] ticks_i,
    output logic       expired_o
);

    localparam int PW = (DELAY_UNIT > 1) ? $clog2(DELAY_UNIT) : 1;
    localparam logic [PW-1:0] PRE_RELOAD = PW'(DELAY_UNIT - 1);

    logic [7:0]    ticks;
    logic [PW-1:0] pre;
    logic          active;

    // Combinational so the owner leaves its wait state exactly on the last cycle.
    assign expired_o = active && (pre == '0) && (ticks == 8'd1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ticks  <= 8'd0;
            pre    <= '0;
            active <= 1'b0;
        end else if (load_i) begin
            ticks  <= ticks_i;
            pre    <= PRE_RELOAD;
            active <= (ticks_i != 8'd0);
        end else if (active) begin
            if (pre == '0) begin
                if (ticks == 8'd1) begin
                    active <= 1'b0;
                end else begin
                    ticks <= ticks - 8'd1;
                    pre   <= PRE_RELOAD;
                end
            end else begin
                pre <= pre - 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/i2c_cfg_seq.sv
// ============================================================================
// Module  : i2c_cfg_seq
// Brief   : Walks a register table ROM and issues I2C writes with retry,
//           inline delays and done/error reporting.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_cfg_seq
    import i2c_cfg_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR   = 7'h39,
    parameter int          N_ENTRIES  = 64,
    parameter int          DELAY_UNIT = 100000,
    parameter int          MAX_RETRY  = 3,
    parameter bit          AUTO_START = 1'b1,
    localparam int         IW         = $clog2(N_ENTRIES)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic [IW-1:0] err_idx_o,
    output logic [IW-1:0] tbl_addr_o,
    input  logic [15:0]   tbl_data_i,
    output logic          req_valid_o,
    input  logic          req_ready_i,
    output logic [6:0]    req_dev_o,
    output logic [7:0]    req_reg_o,
    output logic [7:0]    req_data_o,
    input  logic          rsp_valid_i,
    input  logic          rsp_nack_i
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_ENTRIES - 1);

    state_t        state;
    logic          auto_go;
    logic [IW-1:0] idx;
    logic [RW-1:0] retry;
    logic [IW-1:0] err_idx;
    logic [7:0]    req_reg;
    logic [7:0]    req_data;
    entry_t        ent;
    entry_kind_e   kind;
    logic          dly_load;
    logic          dly_expired;

    assign ent      = entry_t'(tbl_data_i);
    assign kind     = classify(ent);
    assign dly_load = (state == ST_DECODE) && (kind == ENT_DELAY) && (ent.val != 8'd0);

    cfg_delay_timer #(
        .DELAY_UNIT (DELAY_UNIT)
    ) u_delay (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .load_i    (dly_load),
        .ticks_i   (ent.val),
        .expired_o (dly_expired)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= ST_IDLE;
            auto_go  <= AUTO_START;
            idx      <= '0;
            retry    <= '0;
            err_idx  <= '0;
            req_reg  <= 8'd0;
            req_data <= 8'd0;
        end else begin
            auto_go <= 1'b0;
            case (state)
                // auto_go is only ever set in the first cycle after reset, in IDLE.
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start_i || auto_go) begin
                        state <= ST_FETCH;
                        idx   <= '0;
                        retry <= '0;
                    end
                end
                ST_FETCH:  state <= ST_DECODE;
                ST_DECODE: begin
                    case (kind)
                        ENT_END:   state <= ST_DONE;
                        ENT_DELAY: state <= (ent.val == 8'd0) ? ST_NEXT : ST_WAIT_DLY;
                        default: begin
                            req_reg  <= ent.addr;
                            req_data <= ent.val;
                            state    <= ST_ISSUE;
                        end
                    endcase
                end
                ST_ISSUE: begin
                    if (req_ready_i) state <= ST_WAIT_RSP;
                end
                ST_WAIT_RSP: begin
                    if (rsp_valid_i) begin
                        if (!rsp_nack_i) begin
                            retry <= '0;
                            state <= ST_NEXT;
                        end else if (retry < RETRY_MAX) begin
                            retry <= retry + 1'b1;
                            state <= ST_ISSUE;
                        end else begin
                            err_idx <= idx;
                            state   <= ST_ERROR;
                        end
                    end
                end
                ST_WAIT_DLY: begin
                    if (dly_expired) state <= ST_NEXT;
                end
                ST_NEXT: begin
                    if (idx == IDX_LAST) begin
                        state <= ST_DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= ST_FETCH;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy_o      = (state != ST_IDLE) && (state != ST_DONE) && (state != ST_ERROR);
    assign done_o      = (state == ST_DONE);
    assign err_o       = (state == ST_ERROR);
    assign err_idx_o   = err_idx;
    assign tbl_addr_o  = idx;
    assign req_valid_o = (state == ST_ISSUE);
    assign req_dev_o   = DEV_ADDR;
    assign req_reg_o   = req_reg;
    assign req_data_o  = req_data;

endmodule

`default_nettype wire

// File: tb/tb_i2c_cfg_seq.sv
// ============================================================================
// Module  : tb_i2c_cfg_seq
// Brief   : Directed self-checking bench for i2c_cfg_seq with a scripted
//           I2C master responder and a behavioural table ROM.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_cfg_seq;

    localparam int N  = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, err;
    logic [IW-1:0] err_idx, tbl_addr;
    logic [15:0]   tbl_data;
    logic          req_valid, req_ready, rsp_valid, rsp_nack;
    logic [6:0]    req_dev;
    logic [7:0]    req_reg, req_data;

    logic [15:0] rom [N];

    typedef struct {
        logic [6:0] dev;
        logic [7:0] ra;
        logic [7:0] rd;
        int         gap;
        int         vcyc;
    } req_t;

    req_t log_q[$];
    int   cyc = 0;
    int   unstable = 0;
    int   n_total = 0;
    int   n_pass = 0;

    // Responder configuration, written only by the main sequence.
    int         scen = 0;
    int         inject = 0;
    int         ready_lat = 0;
    bit         rsp_hold = 1'b0;
    logic [7:0] nack_reg = 8'h00;
    int         nack_n = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) tbl_data <= rom[tbl_addr];

    i2c_cfg_seq #(
        .DEV_ADDR   (7'h39),
        .N_ENTRIES  (N),
        .DELAY_UNIT (10),
        .MAX_RETRY  (3),
        .AUTO_START (1'b1)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .err_idx_o   (err_idx),
        .tbl_addr_o  (tbl_addr),
        .tbl_data_i  (tbl_data),
        .req_valid_o (req_valid),
        .req_ready_i (req_ready),
        .req_dev_o   (req_dev),
        .req_reg_o   (req_reg),
        .req_data_o  (req_data),
        .rsp_valid_i (rsp_valid),
        .rsp_nack_i  (rsp_nack)
    );

    // Scripted I2C master: acts on negedges, answers one cycle after acceptance.
    initial begin : responder
        int         hold_left, last_rsp, vcount, nack_given, seen_scen, seen_inj, cgap;
        bit         holding, pend, pend_nack;
        logic [6:0] cdev;
        logic [7:0] creg, cdat;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_nack = 1'b0;
        holding = 1'b0; pend = 1'b0; pend_nack = 1'b0; last_rsp = 0; vcount = 0;
        nack_given = 0; seen_scen = 0; seen_inj = 0; hold_left = 0; cgap = 0;
        cdev = '0; creg = '0; cdat = '0;
        forever begin
            @(negedge clk);
            rsp_valid = 1'b0; rsp_nack = 1'b0; req_ready = 1'b0;
            if (scen != seen_scen) begin seen_scen = scen; nack_given = 0; end
            if (!rst_n) begin
                holding = 1'b0; pend = 1'b0;
            end else if (inject != seen_inj) begin
                seen_inj = inject; rsp_valid = 1'b1; rsp_nack = 1'b1;
            end else if (pend) begin
                if (!rsp_hold) begin
                    rsp_valid = 1'b1; rsp_nack = pend_nack; pend = 1'b0; last_rsp = cyc;
                end
            end else if (req_valid) begin
                if (!holding) begin
                    holding = 1'b1; hold_left = ready_lat; vcount = 0;
                    cdev = req_dev; creg = req_reg; cdat = req_data; cgap = cyc - last_rsp;
                end else if (req_dev !== cdev || req_reg !== creg || req_data !== cdat) begin
                    unstable++;
                end
                vcount++;
                if (hold_left == 0) begin
                    req_ready = 1'b1; holding = 1'b0; pend = 1'b1;
                    pend_nack = (creg == nack_reg) && (nack_given < nack_n);
                    if (pend_nack) nack_given++;
                    log_q.push_back('{cdev, creg, cdat, cgap, vcount});
                end else begin
                    hold_left--;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_end(input string tag);
        int k = 0;
        while (!(done || err) && k < 3000) begin
            @(posedge clk); #1; k++;
        end
        chk({tag, " finish"}, 32'(done || err), 32'd1);
    endtask

    task automatic start_pulse();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
    endtask

    task automatic fill_rom();
        for (int i = 0; i < N; i++) rom[i] = 16'hFFFF;
    endtask

    task automatic chk_req(input string tag, input int i, input logic [7:0] ra, input logic [7:0] rd);
        if (i < log_q.size()) begin
            chk({tag, " dev"}, 32'(log_q[i].dev), 32'h39);
            chk({tag, " reg"}, 32'(log_q[i].ra), 32'(ra));
            chk({tag, " data"}, 32'(log_q[i].rd), 32'(rd));
        end else begin
            chk({tag, " present"}, 32'(log_q.size()), 32'(i + 1));
        end
    endtask

    initial begin : main
        int base;
        // Reset values and auto-start, two plain writes.
        fill_rom();
        rom[0] = 16'h4110; rom[1] = 16'h9803;
        #12;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst err", 32'(err), 32'd0);
        chk("rst err_idx", 32'(err_idx), 32'd0);
        chk("rst tbl_addr", 32'(tbl_addr), 32'd0);
        chk("rst req_valid", 32'(req_valid), 32'd0);
        chk("rst req_reg", 32'(req_reg), 32'd0);
        chk("rst req_data", 32'(req_data), 32'd0);
        chk("rst req_dev", 32'(req_dev), 32'h39);
        @(posedge clk); #2 rst_n = 1'b1;
        #1 chk("pre-edge busy", 32'(busy), 32'd0);
        @(posedge clk); #1 chk("autostart busy", 32'(busy), 32'd1);
        base = log_q.size();
        wait_end("s1");
        chk("s1 count", 32'(log_q.size() - base), 32'd2);
        chk_req("s1 r0", base, 8'h41, 8'h10);
        chk_req("s1 r1", base + 1, 8'h98, 8'h03);
        if (log_q.size() > base + 1) chk("s1 write gap", 32'(log_q[base + 1].gap), 32'd4);
        chk("s1 done", 32'(done), 32'd1);
        chk("s1 err", 32'(err), 32'd0);
        chk("s1 busy", 32'(busy), 32'd0);

        // Entry 1 NACKed twice then ACKed.
        scen++; nack_reg = 8'h98; nack_n = 2;
        base = log_q.size();
        start_pulse();
        wait_end("s2");
        chk("s2 count", 32'(log_q.size() - base), 32'd4);
        chk_req("s2 r0", base, 8'h41, 8'h10);
        for (int i = 1; i < 4; i++) chk_req("s2 retry", base + i, 8'h98, 8'h03);
        chk("s2 done", 32'(done), 32'd1);
        chk("s2 err", 32'(err), 32'd0);

        // Entry 2 NACKed four times: retries exhausted.
        fill_rom();
        rom[0] = 16'h4110; rom[1] = 16'h9803; rom[2] = 16'h2255; rom[3] = 16'h3366;
        scen++; nack_reg = 8'h22; nack_n = 4;
        base = log_q.size();
        start_pulse();
        wait_end("s3");
        chk("s3 count", 32'(log_q.size() - base), 32'd6);
        for (int i = 2; i < 6; i++) chk_req("s3 nack", base + i, 8'h22, 8'h55);
        chk("s3 err", 32'(err), 32'd1);
        chk("s3 err_idx", 32'(err_idx), 32'd2);
        chk("s3 done", 32'(done), 32'd0);
        chk("s3 busy", 32'(busy), 32'd0);
        repeat (20) @(posedge clk);
        #1 chk("s3 quiet", 32'(log_q.size() - base), 32'd6);

        // Delay entries: val=3 (30 cycles) and val=0 (none); start while busy ignored.
        fill_rom();
        rom[0] = 16'h4110; rom[1] = 16'hFE03; rom[2] = 16'h9803; rom[3] = 16'hFE00; rom[4] = 16'h5501;
        scen++; nack_n = 0;
        base = log_q.size();
        start_pulse();
        repeat (15) @(posedge clk);
        start_pulse();
        wait_end("s4");
        chk("s4 count", 32'(log_q.size() - base), 32'd3);
        chk_req("s4 r0", base, 8'h41, 8'h10);
        chk_req("s4 r1", base + 1, 8'h98, 8'h03);
        chk_req("s4 r2", base + 2, 8'h55, 8'h01);
        if (log_q.size() > base + 2) begin
            chk("s4 gap dly3", 32'(log_q[base + 1].gap), 32'd37);
            chk("s4 gap dly0", 32'(log_q[base + 2].gap), 32'd7);
        end
        chk("s4 done", 32'(done), 32'd1);

        // Back-pressure: ready held low for 7 cycles.
        fill_rom();
        rom[0] = 16'h7A5C;
        scen++; ready_lat = 7;
        base = log_q.size();
        start_pulse();
        wait_end("s5");
        chk("s5 count", 32'(log_q.size() - base), 32'd1);
        chk_req("s5 r0", base, 8'h7A, 8'h5C);
        if (log_q.size() > base) chk("s5 valid cycles", 32'(log_q[base].vcyc), 32'd8);
        chk("s5 stable", 32'(unstable), 32'd0);
        chk("s5 done", 32'(done), 32'd1);

        // No END entry: all N entries written, then done.
        for (int i = 0; i < N; i++) rom[i] = {8'(i), 8'(8'hA0 + i)};
        scen++; ready_lat = 0;
        base = log_q.size();
        start_pulse();
        wait_end("s6");
        chk("s6 count", 32'(log_q.size() - base), 32'(N));
        chk_req("s6 first", base, 8'h00, 8'hA0);
        chk_req("s6 last", base + N - 1, 8'h07, 8'hA7);
        chk("s6 done", 32'(done), 32'd1);

        // Reset while waiting for a response; late response after restart ignored.
        fill_rom();
        rom[0] = 16'h4110; rom[1] = 16'h9803;
        scen++; rsp_hold = 1'b1;
        base = log_q.size();
        start_pulse();
        for (int k = 0; k < 50 && log_q.size() == base; k++) @(posedge clk);
        chk("s7 accepted", 32'(log_q.size() - base), 32'd1);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk("s7 rst busy", 32'(busy), 32'd0);
        chk("s7 rst valid", 32'(req_valid), 32'd0);
        chk("s7 rst reg", 32'(req_reg), 32'd0);
        chk("s7 rst data", 32'(req_data), 32'd0);
        chk("s7 rst done", 32'(done), 32'd0);
        chk("s7 rst err", 32'(err), 32'd0);
        rsp_hold = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1 chk("s7 restart busy", 32'(busy), 32'd1);
        #1 inject++;
        wait_end("s7");
        chk("s7 count", 32'(log_q.size() - base), 32'd3);
        chk_req("s7 r0", base + 1, 8'h41, 8'h10);
        chk_req("s7 r1", base + 2, 8'h98, 8'h03);
        chk("s7 done", 32'(done), 32'd1);
        chk("s7 err", 32'(err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
